mbist_march_ctrl: RTL and testbench

March C- BIST controller that drives the fault-injectable memory model directly through its `write_read`/`address`/`wdata` port and checks its `rdata`. It sits directly upstream of the memory. It issues one memory operation per clock, accounts for the memory's one-cycle write-data skew and two-cycle read latency, and reports pass/fail with first-fail diagnostics.

---
 rtl/mbist_march_ctrl.sv | 124 ++++++++++++
 tb/tb_mbist_march_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST controller issuing one op per clock to a memory with 1-cycle wdata skew and 2-cycle read latency
// Ports: clk, rst_n (async active-low); start/busy/done/fail run control and status;
// fail_addr/fail_elem/fail_data first-miscompare diagnostics; mem_write_read/mem_address/mem_wdata drive the memory, mem_rdata returns from it.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int CAPACITY     = 15,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(CAPACITY);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  // e/a/ph: position of the op to present at the next issuing edge
  logic [2:0] e, e_s;
  logic [ADDR_WIDTH-1:0] a, a_s;
  logic ph, ph_s;
  logic two, two_s, desc, end_addr, last_op, op_wr, op_dat, dat_s;
  logic accept, issue, miscmp, abort;
  logic cur_rd, cur_exp;
  logic [2:0] cur_elem;
  logic p0_v, p0_x, p1_v, p1_x;
  logic [ADDR_WIDTH-1:0] p0_a, p1_a;
  logic [2:0] p0_e, p1_e;
  always_comb begin
    two      = e != 3'd0 && e != 3'd5;
    desc     = e == 3'd3 || e == 3'd4;
    end_addr = desc ? a == '0 : a == CAP;
    last_op  = e == 3'd5 && end_addr;
    op_wr    = e == 3'd0 || (two && ph);
    // elements 1..4 alternate backgrounds; odd elements start with r0, even with r1
    op_dat   = two && (ph ^ ~e[0]);
    ph_s     = two && !ph;
    e_s      = (!ph_s && end_addr) ? (last_op ? 3'd0 : e + 3'd1) : e;
    a_s      = ph_s ? a : !end_addr ? (desc ? a - 1'b1 : a + 1'b1) : (e == 3'd2 || e == 3'd3) ? CAP : '0;
    two_s    = e_s != 3'd0 && e_s != 3'd5;
    // wdata leads by one op, so it carries the successor's data
    dat_s    = two_s && (ph_s ^ ~e_s[0]);
    miscmp   = p1_v && mem_rdata != {DATA_WIDTH{p1_x}};
    abort    = STOP_ON_FAIL != 0 && miscmp;
    accept   = start && (state == IDLE || state == DONE);
    issue    = (accept || state == RUN) && !abort;
    state_nxt = abort ? DONE
              : accept ? RUN
              : (state == RUN && last_op) ? DRAIN
              : (state == DRAIN && !cur_rd && !p0_v) ? DONE
              : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= '0;
      a <= '0;
      ph <= 1'b0;
      mem_write_read <= 1'b0;
      mem_address <= '0;
      mem_wdata <= '0;
      cur_rd <= 1'b0;
      cur_exp <= 1'b0;
      cur_elem <= '0;
      p0_v <= 1'b0;
      p0_x <= 1'b0;
      p0_a <= '0;
      p0_e <= '0;
      p1_v <= 1'b0;
      p1_x <= 1'b0;
      p1_a <= '0;
      p1_e <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      e <= issue ? e_s : '0;
      a <= issue ? a_s : '0;
      ph <= issue && ph_s;
      mem_write_read <= issue && op_wr;
      mem_address <= issue ? a : '0;
      mem_wdata <= {DATA_WIDTH{issue && dat_s}};
      cur_rd <= issue && !op_wr;
      cur_exp <= op_dat;
      cur_elem <= e;
      // entries enter when the memory samples the read, so stage 1 lines up with rdata
      p0_v <= cur_rd && !abort;
      p0_x <= cur_exp;
      p0_a <= mem_address;
      p0_e <= cur_elem;
      p1_v <= p0_v && !abort;
      p1_x <= p0_x;
      p1_a <= p0_a;
      p1_e <= p0_e;
      busy <= state_nxt == RUN || state_nxt == DRAIN;
      done <= state_nxt == DONE;
      fail <= !accept && (fail || miscmp);
      if (accept) begin
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end else if (miscmp && !fail) begin
        fail_addr <= p1_a;
        fail_elem <= p1_e;
        fail_data <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: checks two controllers (STOP_ON_FAIL 0 and 1) against a March C- reference over fault-injectable memory models
module tb_mbist_march_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] start, busy, done, fail, wr;
  logic [1:0][3:0] addr, fail_addr;
  logic [1:0][2:0] fail_elem;
  logic [1:0][7:0] wdata, rdata, fail_data, wdq, rq;
  logic [1:0][15:0][7:0] mem;
  bit fen;
  int fa, fc, fv, fb;
  int passed = 0, total = 0;
  typedef struct { bit w; int a; logic [7:0] d; int e; } op_t;
  op_t ops[$];
  logic [12:0] exp_lg [162];
  logic [12:0] lg [200];
  int lgn = 0, lg_len = 0;
  bit e0_ok, e1_ok;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : ch
    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15), .STOP_ON_FAIL(g)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]), .done(done[g]), .fail(fail[g]),
      .fail_addr(fail_addr[g]), .fail_elem(fail_elem[g]), .fail_data(fail_data[g]),
      .mem_write_read(wr[g]), .mem_address(addr[g]), .mem_wdata(wdata[g]), .mem_rdata(rdata[g]));
  end
  // memory: wdata registered a cycle before use, 2-cycle read latency, coupling fault on writes to fa
  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      wdq[g] <= wdata[g];
      rq[g] <= mem[g][addr[g]];
      rdata[g] <= rq[g];
      if (wr[g]) begin
        if (fen && int'(addr[g]) == fa && wdq[g][fb] && !mem[g][fc][fb]) mem[g][fv][fb] <= ~mem[g][fv][fb];
        mem[g][addr[g]] <= wdq[g];
      end
    end
  always @(posedge clk)
    if (busy[0]) begin
      if (lgn < 200) lg[lgn] <= {wr[0], addr[0], wdata[0]};
      lgn <= lgn + 1;
    end else if (lgn != 0) begin
      lg_len <= lgn;
      lgn <= 0;
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic build_ops();
    int march [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
    op_t o;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 2; j++)
          if (march[e][j] >= 0) begin
            o.w = march[e][j] < 2;
            o.a = (e == 3 || e == 4) ? 15 - i : i;
            o.d = (march[e][j] % 2) != 0 ? 8'hFF : 8'h00;
            o.e = e;
            ops.push_back(o);
          end
    for (int k = 0; k < 162; k++)
      exp_lg[k] = k < 160 ? {ops[k].w, 4'(ops[k].a), k < 159 ? ops[k+1].d : 8'h00} : 13'h0;
  endtask
  task automatic ref_run(output bit f, output logic [3:0] ra, output logic [2:0] re, output logic [7:0] rd, output int rk);
    logic [7:0] m [16];
    foreach (m[i]) m[i] = 8'h00;
    f = 0; ra = 0; re = 0; rd = 0; rk = -1;
    foreach (ops[k]) begin
      if (ops[k].w) begin
        if (fen && ops[k].a == fa && ops[k].d[fb] && !m[fc][fb]) m[fv][fb] = ~m[fv][fb];
        m[ops[k].a] = ops[k].d;
      end else if (!f && m[ops[k].a] != ops[k].d) begin
        f = 1; rk = k; ra = 4'(ops[k].a); re = 3'(ops[k].e); rd = m[ops[k].a];
      end
    end
  endtask
  task automatic kick(input bit hold);
    start = 2'b11;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 2'b00;
  endtask
  task automatic wait_done(output int td0, output int td1, output int bc, output bit w1);
    td0 = -1; td1 = -1; bc = 0; w1 = 0;
    for (int t = 0; t <= 400 && (td0 < 0 || td1 < 0); t++) begin
      if (t > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (busy[0]) bc++;
      if (td1 >= 0 && wr[1]) w1 = 1;
      if (td0 < 0 && done[0]) td0 = t;
      if (td1 < 0 && done[1]) td1 = t;
      if (t == 16) begin
        e0_ok = 1;
        for (int i = 0; i < 16; i++) if (mem[0][i] !== 8'h00) e0_ok = 0;
      end
      if (t == 48) begin
        e1_ok = 1;
        for (int i = 0; i < 16; i++) if (mem[0][i] !== 8'hFF) e1_ok = 0;
      end
    end
  endtask
  initial begin
    int td0, td1, bc, rk, bad;
    bit w1, rf;
    logic [3:0] ra;
    logic [2:0] re;
    logic [7:0] rd;
    build_ops();
    rst_n = 1'b1;
    start = 2'b00;
    fen = 0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", 64'({busy, done, fail, wr, addr, wdata, fail_addr, fail_elem, fail_data}), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick(0);
    wait_done(td0, td1, bc, w1);
    @(negedge clk);
    chk("ff_done_t", 64'(td0), 64'd162);
    chk("ff_done_t_stop", 64'(td1), 64'd162);
    chk("ff_busy_cycles", 64'(bc), 64'd162);
    chk("ff_fail", 64'(fail), 64'd0);
    chk("ff_done_level", 64'(done), 64'd3);
    chk("ff_mem_after_e0", 64'(e0_ok), 64'd1);
    chk("ff_mem_after_e1", 64'(e1_ok), 64'd1);
    chk("ff_log_len", 64'(lg_len), 64'd162);
    bad = 0;
    for (int k = 0; k < 162; k++) if (lg[k] !== exp_lg[k]) bad++;
    chk("ff_op_stream_errs", 64'(bad), 64'd0);
    fen = 1; fa = 5; fc = 6; fv = 4; fb = 5;
    ref_run(rf, ra, re, rd, rk);
    kick(0);
    wait_done(td0, td1, bc, w1);
    chk("cf_fail", 64'(fail), 64'd3);
    chk("cf_done_t", 64'(td0), 64'd162);
    chk("cf_diag", 64'({fail_addr[0], fail_elem[0], fail_data[0]}), 64'({ra, re, rd}));
    chk("cf_stop_diag", 64'({fail_addr[1], fail_elem[1], fail_data[1]}), 64'({ra, re, rd}));
    chk("cf_stop_done_t", 64'(td1), 64'(rk + 3));
    chk("cf_stop_wr_idle", 64'(w1), 64'd0);
    repeat (4) begin
      fa = int'($urandom_range(0, 15));
      fc = int'($urandom_range(0, 15));
      do fv = int'($urandom_range(0, 15)); while (fv == fa);
      fb = int'($urandom_range(0, 7));
      ref_run(rf, ra, re, rd, rk);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      kick(0);
      wait_done(td0, td1, bc, w1);
      chk("rnd_fail", 64'(fail), rf ? 64'd3 : 64'd0);
      chk("rnd_diag", 64'({fail_addr[0], fail_elem[0], fail_data[0]}), 64'({ra, re, rd}));
      chk("rnd_stop_diag", 64'({fail_addr[1], fail_elem[1], fail_data[1]}), 64'({ra, re, rd}));
      chk("rnd_done_t", 64'(td0), 64'd162);
      chk("rnd_stop_done_t", 64'(td1), rf ? 64'(rk + 3) : 64'd162);
    end
    fen = 0;
    kick(0);
    repeat (50) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1 chk("rst_mid_async", 64'({busy, done, fail, wr, addr, wdata, fail_addr, fail_elem, fail_data}), 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_held", 64'({busy, done, fail, wr, addr, wdata, fail_addr, fail_elem, fail_data}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    kick(0);
    wait_done(td0, td1, bc, w1);
    chk("rerun_done_t", 64'(td0), 64'd162);
    chk("rerun_busy_cycles", 64'(bc), 64'd162);
    chk("rerun_fail", 64'(fail), 64'd0);
    fen = 1; fa = 5; fc = 6; fv = 4; fb = 5;
    ref_run(rf, ra, re, rd, rk);
    kick(1);
    wait_done(td0, td1, bc, w1);
    chk("hold_done_t", 64'(td0), 64'd162);
    chk("hold_fail", 64'(fail[0]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_restart", 64'({busy[0], done[0], fail[0]}), 64'b100);
    start = 2'b00;
    wait_done(td0, td1, bc, w1);
    chk("hold_rerun_done_t", 64'(td0), 64'd162);
    chk("hold_rerun_diag", 64'({fail[0], fail_addr[0], fail_elem[0], fail_data[0]}), 64'({1'b1, ra, re, rd}));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
